uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single rs232tx transmitter between two byte-stream requesters: port 0 is the CPU console from yarvi_soc, port 1 is a debug/status reporter.
- Arbitrates round-robin at line granularity, so lines from the two sources never interleave mid-line.
- Sits between the requesters and rs232tx's valid/ready/data interface.
- Has a registered output stage and starvation guards (burst limit, idle timeout).

Parameters:
- EOL, 8'h0A: byte value that ends a line and releases the grant.
- MAX_BURST, 80: maximum bytes per grant before a forced release; legal range 1..255.
- IDLE_TIMEOUT, 1024: cycles the owner may hold the grant with its valid low before a forced release; must be ≥1.

Ports:
- clock, input, 1: single clock; all state changes on posedge.
- reset, input, 1: asynchronous, active-high.
- s0_valid, input, 1: requester 0 has a byte.
- s0_data, input, 8: requester 0 byte.
- s0_ready, output, 1: requester 0 byte accepted this cycle when s0_valid & s0_ready.
- s1_valid, input, 1: requester 1 has a byte.
- s1_data, input, 8: requester 1 byte.
- s1_ready, output, 1: requester 1 accept.
- tx_valid, output, 1: to rs232tx valid.
- tx_data, output, 8: to rs232tx data.
- tx_ready, input, 1: from rs232tx ready.
- owner, output, 1: index of the current or most recent grantee (debug/LED).
- locked, output, 1: a grant is active.

Behaviour:
- Reset (asynchronous): state=IDLE, tx_valid=0, tx_data=0, owner=1 (so port 0 wins the first arbitration), locked=0, burst count=0, idle count=0. s0_ready=s1_ready=0 while reset is asserted.
- Output register:
  - out_free = ~tx_valid | tx_ready.
  - On an accepted byte: tx_data<=byte, tx_valid<=1.
  - Else if tx_valid & tx_ready: tx_valid<=0.
  - tx_data and tx_valid must never change while tx_valid=1 and tx_ready=0 (AXI-style hold).
  - Latency: input accept at cycle N gives tx_valid at N+1. Sustained throughput is 1 byte/cycle when tx_ready stays high.
- States:
  - IDLE:
    - All s*_ready=0.
    - If exactly one s*_valid is high, grant that port.
    - If both are high, grant the port != owner (round-robin).
    - On a grant: owner<=granted index, locked<=1, counts<=0, go LOCKED next cycle. The grant cycle accepts no byte.
  - LOCKED:
    - s[owner]_ready = out_free; the other port's ready=0.
    - On accept: burst count +1; idle count <=0.
    - Release (go IDLE, locked<=0, owner kept) when the accepted byte == EOL, or when the post-increment burst count == MAX_BURST. The releasing byte is still transferred normally.
    - When the owner's valid is low: idle count +1. When idle count reaches IDLE_TIMEOUT-1, release.
    - Owner valid high but out_free=0: idle count holds; this is not a timeout condition.
- Boundaries:
  - Counter widths are clog2(MAX_BURST+1) and clog2(IDLE_TIMEOUT+1). No wrap: counters clear on release.
  - The output register may still hold the last byte when the state returns to IDLE. It drains independently, and the next grant may start immediately.
  - A requester's valid dropping without a transfer is tolerated (no AXI valid-stability check).
  - Reset mid-byte drops the pending tx byte. rs232tx sees tx_valid fall asynchronously, which is acceptable.

Decomposition:
- Shared package yarvi_uart_pkg holds UART_W=8 and the default EOL/BPS constants.
- One sub-module, uart_out_reg: the 8-bit valid/ready holding register with load/drain logic. The arbiter FSM stays in uart_tx_arbiter.

Test Plan:
- After reset, only s0 sends "AB\n" with tx_ready=1 → tx_data A,B,0A on consecutive cycles starting 2 cycles after s0_valid rises. locked falls the cycle after 0A is accepted. owner=0.
- Both valid from reset, s0="X\n", s1="Y\n" → output order X,0A,Y,0A. A second pair of lines starts with s0 again (alternation). No interleave.
- MAX_BURST=4, s1 streams 10 non-EOL bytes while s0 is valid → release after 4 bytes from s1, then s0 is granted.
- tx_ready held low for 20 cycles mid-line → tx_data/tx_valid stable and s_ready=0 throughout. No timeout release.
- IDLE_TIMEOUT=16, owner sends 1 byte then drops valid → locked falls after 16 idle cycles, and the other requester is then granted.
- Assert reset while locked with tx_valid=1 → tx_valid=0, locked=0, owner=1 immediately (async). The next arbitration favours s0.

Source files
------------

// File: rtl/yarvi_uart_pkg.sv
// Shared UART definitions: byte width, default line terminator and bit rate,
// and the arbiter state encoding.
package yarvi_uart_pkg;

  localparam int UART_W = 8;
  localparam logic [UART_W-1:0] DEFAULT_EOL = 8'h0A;
  localparam int DEFAULT_BPS = 115200;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two requester streams, the stream towards rs232tx, and the
// arbiter's debug outputs (owner, locked, state).
//
// Handshake rule for every valid/ready pair in this bundle: a byte moves on a
// rising clock edge where valid and ready are both high. Ready never depends
// on valid. The tx side holds tx_valid/tx_data stable while tx_valid=1 and
// tx_ready=0. The requester side tolerates valid dropping without a transfer.
interface uart_tx_arbiter_if;
  import yarvi_uart_pkg::*;

  logic              s0_valid;
  logic [UART_W-1:0] s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [UART_W-1:0] s1_data;
  logic              s1_ready;
  logic              tx_valid;
  logic [UART_W-1:0] tx_data;
  logic              tx_ready;
  logic              owner;
  logic              locked;
  arb_state_t        state;

  // Arbiter side
  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, tx_ready,
    output s0_ready, s1_ready, tx_valid, tx_data, owner, locked, state
  );

  // Requesters plus transmitter side
  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, tx_ready,
    input  s0_ready, s1_ready, tx_valid, tx_data, owner, locked, state
  );

endinterface

// File: rtl/uart_out_reg.sv
// Single-entry valid/ready holding register in front of rs232tx.
// A load is only issued while out_free is high, so a byte that is waiting for
// tx_ready is never overwritten.
module uart_out_reg
  import yarvi_uart_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [UART_W-1:0] load_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [UART_W-1:0] tx_data,
  output logic              out_free
);

  // Register can take a new byte when empty or when it empties this cycle.
  assign out_free = ~tx_valid | tx_ready;

  // Load a new byte, or drain the current one once the transmitter takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter sharing rs232tx between the CPU console
// (port 0) and a debug reporter (port 1). A grant lasts until the owner sends
// EOL, sends MAX_BURST bytes, or leaves its valid low for IDLE_TIMEOUT cycles.
module uart_tx_arbiter
  import yarvi_uart_pkg::*;
#(
  parameter logic [UART_W-1:0] EOL          = DEFAULT_EOL,
  parameter int                MAX_BURST    = 80,
  parameter int                IDLE_TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  // Last count values before a forced release (compared pre-increment).
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  arb_state_t        state_q;
  logic              owner_q;
  logic              locked_q;
  logic [BW-1:0]     burst_cnt;
  logic [IW-1:0]     idle_cnt;

  logic              out_free;
  logic              own_valid;
  logic [UART_W-1:0] own_data;
  logic              accept;
  logic              grant_idx;
  logic              tx_valid_w;
  logic [UART_W-1:0] tx_data_w;

  // Select the owner's stream and decide whether a byte moves this cycle.
  always_comb begin
    own_valid = owner_q ? bus.s1_valid : bus.s0_valid;
    own_data  = owner_q ? bus.s1_data  : bus.s0_data;
    accept    = (state_q == ARB_LOCKED) && own_valid && out_free;
    // With both requesting, the port that did not own last wins.
    grant_idx = (bus.s0_valid && bus.s1_valid) ? ~owner_q : bus.s1_valid;
  end

  // Grant tracking, burst limit and idle timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= 1'b1;
      locked_q  <= 1'b0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (bus.s0_valid || bus.s1_valid) begin
            state_q   <= ARB_LOCKED;
            owner_q   <= grant_idx;
            locked_q  <= 1'b1;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            idle_cnt <= '0;
            if ((own_data == EOL) || (burst_cnt == BURST_LAST)) begin
              state_q   <= ARB_IDLE;
              locked_q  <= 1'b0;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (!own_valid) begin
            if (idle_cnt == IDLE_LAST) begin
              state_q   <= ARB_IDLE;
              locked_q  <= 1'b0;
              burst_cnt <= '0;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  uart_out_reg u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .load_data (own_data),
    .tx_ready  (bus.tx_ready),
    .tx_valid  (tx_valid_w),
    .tx_data   (tx_data_w),
    .out_free  (out_free)
  );

  assign bus.s0_ready = (state_q == ARB_LOCKED) && !owner_q && out_free;
  assign bus.s1_ready = (state_q == ARB_LOCKED) &&  owner_q && out_free;
  assign bus.tx_valid = tx_valid_w;
  assign bus.tx_data  = tx_data_w;
  assign bus.owner    = owner_q;
  assign bus.locked   = locked_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter built with MAX_BURST=4, IDLE_TIMEOUT=16.
module tb_uart_tx_arbiter;
  import yarvi_uart_pkg::*;

  logic clock;
  logic reset;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .EOL          (8'h0A),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] s0_q[$];
  logic [7:0] s1_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push(input int port, input logic [7:0] b);
    if (port == 0) s0_q.push_back(b);
    else s1_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_unlock(input int budget);
    int k;
    k = 0;
    while (bus.locked && k < budget) begin
      tick(1);
      k++;
    end
    check("unlock", bus.locked, 0);
  endtask

  // Requester drivers: present the head of each queue, pop after a transfer.
  initial begin
    logic f0, f1;
    bus.s0_valid = 1'b0;
    bus.s0_data  = 8'h00;
    bus.s1_valid = 1'b0;
    bus.s1_data  = 8'h00;
    forever begin
      @(negedge clock);
      f0 = bus.s0_valid & bus.s0_ready;
      f1 = bus.s1_valid & bus.s1_ready;
      @(posedge clock);
      #1;
      if (f0 && s0_q.size() > 0) void'(s0_q.pop_front());
      if (f1 && s1_q.size() > 0) void'(s1_q.pop_front());
      bus.s0_valid = (s0_q.size() > 0);
      bus.s0_data  = (s0_q.size() > 0) ? s0_q[0] : 8'h00;
      bus.s1_valid = (s1_q.size() > 0);
      bus.s1_data  = (s1_q.size() > 0) ? s1_q[0] : 8'h00;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic       hold_v;
    logic [7:0] hold_d;
    logic [7:0] e;
    hold_v = 1'b0;
    hold_d = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", bus.tx_valid, 1);
          check("hold_data", bus.tx_data, hold_d);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            check("tx_byte_unexpected", {24'h0, bus.tx_data}, 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", bus.tx_data, e);
          end
        end
        hold_v = bus.tx_valid & ~bus.tx_ready;
        hold_d = bus.tx_data;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    bus.tx_ready = 1'b1;
    tick(2);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_owner", bus.owner, 1);
    check("rst_s0_ready", bus.s0_ready, 0);
    check("rst_s1_ready", bus.s1_ready, 0);
    check("rst_state", bus.state, ARB_IDLE);
    reset = 1'b0;
    tick(1);

    // s0 alone sends "AB\n": grant cycle, then one byte per cycle.
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h0A);
    tick(1);
    check("t1_idle_s0_ready", bus.s0_ready, 0);
    check("t1_idle_locked", bus.locked, 0);
    tick(1);
    check("t1_grant_locked", bus.locked, 1);
    check("t1_grant_owner", bus.owner, 0);
    check("t1_grant_state", bus.state, ARB_LOCKED);
    check("t1_grant_s0_ready", bus.s0_ready, 1);
    check("t1_grant_tx_valid", bus.tx_valid, 0);
    tick(1);
    check("t1_a_valid", bus.tx_valid, 1);
    check("t1_a_data", bus.tx_data, 8'h41);
    tick(1);
    check("t1_b_data", bus.tx_data, 8'h42);
    tick(1);
    check("t1_eol_data", bus.tx_data, 8'h0A);
    check("t1_eol_locked", bus.locked, 0);
    check("t1_eol_owner", bus.owner, 0);
    tick(1);
    check("t1_drained", bus.tx_valid, 0);
    check("t1_exp_empty", exp_q.size(), 0);

    // Both request from reset: lines alternate, s0 first.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push(0, 8'h58); push(0, 8'h0A);
    push(1, 8'h59); push(1, 8'h0A);
    push(0, 8'h50); push(0, 8'h0A);
    push(1, 8'h51); push(1, 8'h0A);
    exp_q.delete();
    exp_q = '{8'h58, 8'h0A, 8'h59, 8'h0A, 8'h50, 8'h0A, 8'h51, 8'h0A};
    tick(2);
    check("t2_first_owner", bus.owner, 0);
    check("t2_first_s1_ready", bus.s1_ready, 0);
    check("t2_first_s0_ready", bus.s0_ready, 1);
    drain(60);
    check("t2_last_owner", bus.owner, 1);
    check("t2_last_locked", bus.locked, 0);

    // Burst limit: s1 streams 10 bytes, s0 gets in after 4.
    for (int i = 0; i < 10; i++) s1_q.push_back(8'h30 + 8'(i));
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h5A, 8'h0A,
              8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    tick(1);
    s0_q.push_back(8'h5A); s0_q.push_back(8'h0A);
    tick(1);
    check("t3_grant_owner", bus.owner, 1);
    check("t3_grant_s0_ready", bus.s0_ready, 0);
    tick(4);
    check("t3_burst_release", bus.locked, 0);
    check("t3_burst_last", bus.tx_data, 8'h33);
    tick(1);
    check("t3_s0_owner", bus.owner, 0);
    check("t3_s0_locked", bus.locked, 1);
    drain(100);
    wait_unlock(40);
    check("t3_final_owner", bus.owner, 1);

    // Idle timeout: s0 sends one byte, then goes quiet for 16 cycles.
    push(0, 8'h4B);
    tick(2);
    check("t5_owner", bus.owner, 0);
    check("t5_locked", bus.locked, 1);
    tick(1);
    check("t5_k_valid", bus.tx_valid, 1);
    check("t5_k_data", bus.tx_data, 8'h4B);
    push(1, 8'h4D); push(1, 8'h0A);
    tick(15);
    check("t5_still_locked", bus.locked, 1);
    check("t5_s1_blocked", bus.s1_ready, 0);
    check("t5_still_owner", bus.owner, 0);
    tick(1);
    check("t5_timeout_release", bus.locked, 0);
    tick(1);
    check("t5_s1_owner", bus.owner, 1);
    check("t5_s1_locked", bus.locked, 1);
    drain(30);

    // Transmitter stalls for 20 cycles mid-line: no movement, no timeout.
    push(0, 8'h61); push(0, 8'h62); push(0, 8'h0A);
    tick(2);
    check("t4_owner", bus.owner, 0);
    tick(1);
    check("t4_a_valid", bus.tx_valid, 1);
    check("t4_a_data", bus.tx_data, 8'h61);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t4_stall_valid", bus.tx_valid, 1);
      check("t4_stall_data", bus.tx_data, 8'h61);
      check("t4_stall_s0_ready", bus.s0_ready, 0);
      check("t4_stall_locked", bus.locked, 1);
    end
    bus.tx_ready = 1'b1;
    drain(20);
    check("t4_end_locked", bus.locked, 0);

    // Reset while locked with a byte waiting in the output register.
    push(0, 8'h52); push(0, 8'h53);
    tick(2);
    check("t6_owner", bus.owner, 0);
    check("t6_locked", bus.locked, 1);
    tick(1);
    check("t6_r_valid", bus.tx_valid, 1);
    check("t6_r_data", bus.tx_data, 8'h52);
    bus.tx_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_tx_valid", bus.tx_valid, 0);
    check("t6_async_locked", bus.locked, 0);
    check("t6_async_owner", bus.owner, 1);
    check("t6_async_s0_ready", bus.s0_ready, 0);
    check("t6_async_state", bus.state, ARB_IDLE);
    s0_q.delete();
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    bus.tx_ready = 1'b1;
    push(0, 8'h30); push(0, 8'h0A);
    push(1, 8'h31); push(1, 8'h0A);
    tick(2);
    check("t6_rearb_owner", bus.owner, 0);
    check("t6_rearb_locked", bus.locked, 1);
    drain(30);
    check("t6_end_owner", bus.owner, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
